// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// MUL/IMUL use iterative shift-add; DIV/IDIV use restoring division.
module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             c,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             busy
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_IMUL = 4'h3,
        OP_DIV  = 4'h4, OP_IDIV = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
        OP_XOR  = 4'h8, OP_NOT  = 4'h9, OP_LSL  = 4'hA, OP_LSR  = 4'hB,
        OP_ASR  = 4'hC, OP_ROL  = 4'hD, OP_ROR  = 4'hE, OP_CMP  = 4'hF
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIVD, S_DONE} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_result, r_result_hi;
    logic             r_c, r_z, r_v, r_n, r_out_valid;
    logic [WIDTH-1:0] r_acc, r_mq, r_mcand;
    logic             r_signed, r_neg_q, r_neg_r;
    logic [CW-1:0]    r_cnt;

    op_e              w_op;
    logic             w_signed_in;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_res_c, w_res_v;

    assign w_op        = op_e'(opcode);
    assign w_signed_in = (w_op == OP_IMUL) || (w_op == OP_IDIV);
    assign w_mag_a     = (w_signed_in && a[WIDTH-1]) ? -a : a;
    assign w_mag_b     = (w_signed_in && b[WIDTH-1]) ? -b : b;
    assign w_sum       = {1'b0, a} + {1'b0, b};
    assign w_dif       = {1'b0, a} - {1'b0, b};

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_res   = '0;
        w_res_c = 1'b0;
        w_res_v = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_res_c = w_sum[WIDTH];
                w_res_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                w_res   = w_dif[WIDTH-1:0];
                w_res_c = w_dif[WIDTH];
                w_res_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_LSL: begin w_res = {a[WIDTH-2:0], 1'b0};        w_res_c = a[WIDTH-1]; end
            OP_LSR: begin w_res = {1'b0, a[WIDTH-1:1]};        w_res_c = a[0];       end
            OP_ASR: begin w_res = {a[WIDTH-1], a[WIDTH-1:1]};  w_res_c = a[0];       end
            OP_ROL: begin w_res = {a[WIDTH-2:0], a[WIDTH-1]};  w_res_c = a[WIDTH-1]; end
            OP_ROR: begin w_res = {a[0], a[WIDTH-1:1]};        w_res_c = a[0];       end
            default: ;
        endcase
    end

    // One shift-add step: {acc, mq} holds the partial product, mq[0] selects the add.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next, w_prod;
    logic [WIDTH-1:0]   w_prod_lo, w_prod_hi;

    assign w_mul_sum  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_mq[WIDTH-1:1]};
    assign w_prod     = r_neg_q ? -w_mul_next : w_mul_next;
    assign w_prod_lo  = w_prod[WIDTH-1:0];
    assign w_prod_hi  = w_prod[2*WIDTH-1:WIDTH];

    // One restoring step: remainder in acc, dividend shifts out of mq as quotient shifts in.
    logic [WIDTH:0]   w_div_shift, w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_next, w_quo_next, w_quo, w_rem;

    assign w_div_shift = {r_acc, r_mq[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};
    assign w_div_ge    = !w_div_diff[WIDTH];
    assign w_rem_next  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_next  = {r_mq[WIDTH-2:0], w_div_ge};
    assign w_quo       = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_rem       = r_neg_r ? -w_rem_next : w_rem_next;

    logic w_last;
    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_result_hi <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_v         <= 1'b0;
            r_n         <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_mq        <= '0;
            r_mcand     <= '0;
            r_signed    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_signed <= w_signed_in;
                    r_neg_q  <= w_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_r  <= w_signed_in && a[WIDTH-1];
                    r_acc    <= '0;
                    r_cnt    <= CW'(WIDTH);
                    case (w_op)
                        OP_MUL, OP_IMUL: begin
                            r_mcand <= w_mag_a;
                            r_mq    <= w_mag_b;
                            r_state <= S_MULT;
                        end
                        OP_DIV, OP_IDIV: begin
                            if (b == '0) begin
                                r_result    <= '1;
                                r_result_hi <= '0;
                                {r_c, r_z, r_v, r_n} <= 4'b0011;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_mq    <= w_mag_a;
                                r_mcand <= w_mag_b;
                                r_state <= S_DIVD;
                            end
                        end
                        default: begin
                            if (w_op != OP_CMP) begin
                                r_result    <= w_res;
                                r_result_hi <= '0;
                            end
                            r_c         <= w_res_c;
                            r_v         <= w_res_v;
                            r_z         <= (w_res == '0);
                            r_n         <= w_res[WIDTH-1];
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    endcase
                end
                S_MULT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_result    <= w_prod_lo;
                        r_result_hi <= w_prod_hi;
                        r_c         <= 1'b0;
                        r_z         <= (w_prod_lo == '0);
                        r_n         <= w_prod_lo[WIDTH-1];
                        r_v         <= r_signed ? (w_prod_hi != {WIDTH{w_prod_lo[WIDTH-1]}})
                                                : (|w_prod_hi);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc <= w_mul_next[2*WIDTH-1:WIDTH];
                        r_mq  <= w_mul_next[WIDTH-1:0];
                    end
                end
                S_DIVD: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_acc <= w_rem_next;
                    r_mq  <= w_quo_next;
                    if (w_last) begin
                        r_result    <= w_quo;
                        r_result_hi <= w_rem;
                        r_c         <= 1'b0;
                        r_z         <= (w_quo == '0);
                        r_n         <= w_quo[WIDTH-1];
                        // Only MIN / -1 yields a positive magnitude with the sign bit set.
                        r_v         <= r_signed && !r_neg_q && w_quo_next[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign c         = r_c;
    assign z         = r_z;
    assign v         = r_v;
    assign n         = r_n;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8 and WIDTH=16.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, result, result_hi;
    logic [3:0] opcode;
    logic       c, z, v, n;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, busy_w;
    logic [15:0] a_w, b_w, result_w, result_hi_w;
    logic [3:0]  opcode_w;
    logic        c_w, z_w, v_w, n_w;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .c(c), .z(z), .v(v), .n(n), .busy(busy)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .opcode(opcode_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result(result_w), .result_hi(result_hi_w), .c(c_w), .z(z_w), .v(v_w), .n(n_w),
        .busy(busy_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for IDLE, present one request and return just after the transfer edge.
    task automatic start_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("start_ready", {31'd0, in_ready}, 32'd1);
        opcode   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    // Latency counts edges from the transfer edge to the first edge seeing out_valid.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input int lat, input logic [7:0] exp_res,
                          input logic [7:0] exp_hi, input logic [3:0] exp_czvn);
        start_op(op, va, vb);
        wait_result(tag, lat);
        check({tag, "_res"}, {24'd0, result}, {24'd0, exp_res});
        check({tag, "_hi"}, {24'd0, result_hi}, {24'd0, exp_hi});
        check({tag, "_czvn"}, {28'd0, c, z, v, n}, {28'd0, exp_czvn});
        accept();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {in_valid, out_ready, in_valid_w, out_ready_w} = '0;
        a = '0; b = '0; opcode = '0;
        a_w = '0; b_w = '0; opcode_w = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_outs", {result, result_hi, c, z, v, n, out_valid, busy, in_ready}, 32'd1);

        run_op("add_ovf", 4'h0, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'b0011);

        start_op(4'h2, 8'hFF, 8'hFF);
        check("mul_busy", {30'd0, busy, in_ready}, 32'd2);
        wait_result("mul", 9);
        check("mul_res", {result_hi, result}, 32'hFE01);
        check("mul_czvn", {c, z, v, n}, 4'b0010);
        accept();

        run_op("imul", 4'h3, 8'hFE, 8'h03, 9, 8'hFA, 8'hFF, 4'b0001);
        run_op("idiv", 4'h5, 8'hF9, 8'h02, 9, 8'hFD, 8'hFF, 4'b0001);
        run_op("div0", 4'h4, 8'h55, 8'h00, 1, 8'hFF, 8'h00, 4'b0011);
        run_op("idiv_min", 4'h5, 8'h80, 8'hFF, 9, 8'h80, 8'h00, 4'b0011);

        // Backpressure: SUB result held while a pending ADD waits at the input.
        start_op(4'h1, 8'h03, 8'h05);
        wait_result("sub_bp", 1);
        opcode   = 4'h0;
        a        = 8'h01;
        b        = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {result, c, z, v, n, out_valid, in_ready}, {8'hFE, 4'b1001, 2'b10});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_gap", {30'd0, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next", {result, out_valid}, {8'h02, 1'b1});
        accept();

        run_op("add_c", 4'h0, 8'hF8, 8'h18, 1, 8'h10, 8'h00, 4'b1000);
        run_op("cmp_eq", 4'hF, 8'h42, 8'h42, 1, 8'h10, 8'h00, 4'b0100);
        run_op("mul_z", 4'h2, 8'h10, 8'h20, 9, 8'h00, 8'h02, 4'b0110);
        run_op("cmp_lt", 4'hF, 8'h05, 8'h07, 1, 8'h00, 8'h02, 4'b1001);
        run_op("ror", 4'hE, 8'h01, 8'h00, 1, 8'h80, 8'h00, 4'b1001);
        run_op("and", 4'h6, 8'hA5, 8'h3C, 1, 8'h24, 8'h00, 4'b0000);
        run_op("or",  4'h7, 8'hA5, 8'h3C, 1, 8'hBD, 8'h00, 4'b0001);
        run_op("xor", 4'h8, 8'hA5, 8'h3C, 1, 8'h99, 8'h00, 4'b0001);
        run_op("not", 4'h9, 8'hA5, 8'h3C, 1, 8'h5A, 8'h00, 4'b0000);
        run_op("lsl", 4'hA, 8'hA5, 8'h3C, 1, 8'h4A, 8'h00, 4'b1000);
        run_op("lsr", 4'hB, 8'hA5, 8'h3C, 1, 8'h52, 8'h00, 4'b1000);
        run_op("asr", 4'hC, 8'hA5, 8'h3C, 1, 8'hD2, 8'h00, 4'b1001);
        run_op("rol", 4'hD, 8'hA5, 8'h3C, 1, 8'h4B, 8'h00, 4'b1000);

        // Reset in the middle of a multiply aborts it with no output.
        start_op(4'h2, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid", {result, result_hi, c, z, v, n, out_valid, busy, in_ready}, 32'd1);
        run_op("div_post", 4'h4, 8'h64, 8'h07, 9, 8'h0E, 8'h02, 4'b0000);

        begin
            int lat;
            @(negedge clk);
            check("w16_ready", {31'd0, in_ready_w}, 32'd1);
            opcode_w   = 4'h2;
            a_w        = 16'hFFFF;
            b_w        = 16'hFFFF;
            in_valid_w = 1'b1;
            @(posedge clk);
            #1;
            in_valid_w = 1'b0;
            a_w        = 16'h1234;
            lat        = 1;
            @(negedge clk);
            while (!out_valid_w && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check("w16_mul_lat", lat, 17);
            check("w16_mul_res", {result_hi_w, result_w}, 32'hFFFE_0001);
            check("w16_mul_czvn", {c_w, z_w, v_w, n_w}, 4'b0010);
            out_ready_w = 1'b1;
            @(negedge clk);
            out_ready_w = 1'b0;
            check("w16_idle", {30'd0, out_valid_w, in_ready_w}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU.
- Keeps the 4-bit opcode map and the C/Z/V/N flag semantics; operand width is set by WIDTH.
- MUL/IMUL/DIV/IDIV use iterative shift-add and restoring-divide datapaths instead of wide combinational operators.
- Sits between the decode/register-read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CW, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE; transfer on in_valid&&in_ready
- a  in  WIDTH  operand A, sampled at transfer
- b  in  WIDTH  operand B, sampled at transfer
- opcode  in  4  operation, sampled at transfer
- out_valid  out  1  result and flags valid, held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  low result / quotient
- result_hi  out  WIDTH  high product / remainder; 0 for other ops
- c  out  1  carry/borrow
- z  out  1  zero
- v  out  1  overflow
- n  out  1  negative
- busy  out  1  state != IDLE

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 IMUL, 4 DIV, 5 IDIV, 6 AND, 7 OR, 8 XOR, 9 NOT(a), A LSL1, B LSR1, C ASR1, D ROL1, E ROR1, F CMP.
- Reset (async, any state): state=IDLE; result=0, result_hi=0; c=v=n=z=0; out_valid=0; iteration counter=0.
- States:
  - IDLE: in_ready=1. On transfer, single-cycle ops -> DONE; MUL/IMUL -> MULT; DIV/IDIV with b!=0 -> DIVD; DIV/IDIV with b==0 -> DONE.
  - MULT: WIDTH cycles of shift-add on operand magnitudes, then -> DONE.
  - DIVD: WIDTH cycles of restoring divide on operand magnitudes, then -> DONE.
  - DONE: out_valid=1; result, result_hi and flags stable. out_ready=1 -> IDLE next cycle.
- Latency, with transfer at edge k:
  - Single-cycle ops and divide-by-zero: out_valid from edge k+1.
  - MUL/IMUL/DIV/IDIV: out_valid from edge k+WIDTH+1.
  - Minimum of one IDLE cycle between results, so no back-to-back acceptance.
- Flags, common rules:
  - z = (result==0); n = result[WIDTH-1].
  - c=0 and v=0 unless stated below.
- ADD: {c,result} = a+b; v = signed overflow.
- SUB: result = a-b; c = borrow (a<b unsigned); v = signed overflow.
- MUL (unsigned): {result_hi,result} = a*b, full 2*WIDTH bits; v = |result_hi.
- IMUL (signed): 2*WIDTH two's-complement product; magnitudes are multiplied and the product negated if signs differ. v = (result_hi != {WIDTH{result[WIDTH-1]}}). This is a deliberate change from the 8-bit ALU, which flagged any nonzero high byte.
- DIV/IDIV divide by zero: result=all ones, result_hi=0, v=1.
- IDIV: quotient truncates toward zero; remainder sign = dividend sign.
- IDIV with a=MIN and b=-1: result=MIN, result_hi=0, v=1.
- Shifts and rotates: c = bit shifted out (a[WIDTH-1] for LSL/ROL, a[0] for LSR/ASR/ROR). ASR replicates the sign bit.
- CMP: result and result_hi are NOT updated and keep their previous values. Flags (c, v, z, n) are computed from a-b exactly as for SUB.
- result_hi is forced to 0 for every op other than MUL/IMUL/DIV/IDIV. CMP is the exception and holds its previous value.
- Inputs are ignored while busy; a, b and opcode may change freely after transfer.
- Reset asserted mid-iteration aborts the operation and produces no output.

Test Plan:
- WIDTH=8, ADD a=8'h7F b=8'h01 -> out_valid at k+1; result=8'h80, v=1, n=1, c=0, z=0.
- WIDTH=8, MUL a=8'hFF b=8'hFF -> out_valid exactly at k+9; result=8'h01, result_hi=8'hFE, v=1. Then IMUL a=8'hFE(-2) b=8'h03 -> result=8'hFA, result_hi=8'hFF, v=0.
- WIDTH=8, IDIV a=8'hF9(-7) b=8'h02 -> result=8'hFD(-3), result_hi=8'hFF(-1), v=0. Then DIV b=0 -> at k+1, result=8'hFF, result_hi=0, v=1. Then IDIV a=8'h80 b=8'hFF -> result=8'h80, v=1.
- Backpressure: hold out_ready=0 for 5 cycles after a SUB 8'h03-8'h05 -> result=8'hFE, c=1, n=1 stable with out_valid=1 and in_ready=0 throughout; accepts next op only after the out_ready handshake plus one IDLE cycle.
- CMP a=b=8'h42 following an ADD with result=8'h10 -> z=1, c=0, and result stays 8'h10. ROR a=8'h01 -> result=8'h80, c=1.
- Assert rst at cycle 4 of a MUL -> all outputs 0 and in_ready=1 immediately after release; a new DIV 8'h64/8'h07 then returns result=8'h0E, result_hi=8'h02. Repeat the MUL case at WIDTH=16 (16'hFFFF*16'hFFFF) -> result=16'h0001, result_hi=16'hFFFE, latency 17.
